gmii_rx_framer: RTL and testbench

//  Receive-side framer feeding the TCP extractor's byte-stream input (newpkt/dataValid/data).

---
 rtl/eth_pkg.sv | 24 ++
 rtl/eth_crc32_d8.sv | 21 ++
 rtl/gmii_rx_framer.sv | 142 ++++++++++++++
 tb/tb_gmii_rx_framer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and receive-FSM state encoding for the GMII framer and TX path.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          ETH_MIN_FRAME = 64;
  localparam int          ETH_MAX_FRAME = 1518;

  // state    | meaning
  // ST_IDLE  | waiting for rx_dv
  // ST_PRE   | inside preamble, waiting for SFD
  // ST_DATA  | receiving frame bytes after SFD
  // ST_DROP  | malformed preamble, discard until rx_dv drops
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rxState_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational byte-wide CRC-32 step, reflected polynomial, data consumed LSB first.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crcIn,
  input  logic [7:0]  dataIn,
  output logic [31:0] crcOut
);

  logic [31:0] c;

  always_comb begin
    c = crcIn;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ dataIn[i]) c = (c >> 1) ^ CRC32_POLY;
      else                  c = c >> 1;
    end
    crcOut = c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, withholds the FCS through a 4-byte delay line,
// checks CRC-32 and keeps saturating frame statistics.
module gmii_rx_framer
  import eth_pkg::*;
#(
  parameter int MAX_LEN = ETH_MAX_FRAME,
  parameter int MIN_LEN = ETH_MIN_FRAME,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [7:0]       rxd,
  output logic             newpkt,
  output logic             dataValid,
  output logic [7:0]       data,
  output logic             pktEnd,
  output logic [LEN_W-1:0] pktLen,
  output logic             fcsErr,
  output logic             frameErr,
  output logic             runt,
  output logic             oversize,
  output logic [CNT_W-1:0] cntFrames,
  output logic [CNT_W-1:0] cntFcsErr,
  output logic [CNT_W-1:0] cntRunt,
  output logic [CNT_W-1:0] cntOvr
);

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_LEN_W = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] OVR_LEN_W = LEN_W'(MAX_LEN + 1);

  rxState_t         state;
  logic [31:0]      crc;
  logic [31:0]      crcNext;
  logic [LEN_W-1:0] lenCnt;
  logic [LEN_W-1:0] lenNext;
  logic [3:0][7:0]  dly;
  logic [2:0]       fill;
  logic             erSeen;
  logic             lineFull;
  logic             overNext;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  eth_crc32_d8 uCrc (
    .crcIn  (crc),
    .dataIn (rxd),
    .crcOut (crcNext)
  );

  // Length saturates one past the maximum so oversize stays visible without wrapping.
  assign lenNext  = (lenCnt >= OVR_LEN_W) ? lenCnt : lenCnt + LEN_W'(1);
  assign overNext = (lenNext > MAX_LEN_W);
  assign lineFull = (fill == 3'd4);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      crc       <= CRC32_INIT;
      lenCnt    <= '0;
      dly       <= '0;
      fill      <= '0;
      erSeen    <= 1'b0;
      newpkt    <= 1'b0;
      dataValid <= 1'b0;
      data      <= '0;
      pktEnd    <= 1'b0;
      pktLen    <= '0;
      fcsErr    <= 1'b0;
      frameErr  <= 1'b0;
      runt      <= 1'b0;
      oversize  <= 1'b0;
      cntFrames <= '0;
      cntFcsErr <= '0;
      cntRunt   <= '0;
      cntOvr    <= '0;
    end else begin
      newpkt    <= 1'b0;
      dataValid <= 1'b0;
      pktEnd    <= 1'b0;

      case (state)
        ST_IDLE, ST_PRE: begin
          if (!rx_dv) begin
            state <= ST_IDLE;
          end else if (rxd == ETH_SFD) begin
            state  <= ST_DATA;
            newpkt <= 1'b1;
            crc    <= CRC32_INIT;
            lenCnt <= '0;
            dly    <= '0;
            fill   <= '0;
            erSeen <= 1'b0;
          end else if (rxd == ETH_PREAMBLE) begin
            state <= ST_PRE;
          end else begin
            state <= ST_DROP;
          end
        end

        ST_DATA: begin
          if (rx_dv) begin
            crc    <= crcNext;
            lenCnt <= lenNext;
            dly    <= {dly[2:0], rxd};
            if (!lineFull) fill <= fill + 3'd1;
            if (rx_er) erSeen <= 1'b1;
            // The oldest byte leaves as the newest arrives; nothing leaves once oversize.
            if (lineFull && !overNext) begin
              dataValid <= 1'b1;
              data      <= dly[3];
            end
          end else begin
            state     <= ST_IDLE;
            pktEnd    <= 1'b1;
            pktLen    <= lenCnt;
            fcsErr    <= (crc != CRC32_RESIDUE);
            frameErr  <= erSeen;
            runt      <= (lenCnt < MIN_LEN_W);
            oversize  <= (lenCnt > MAX_LEN_W);
            cntFrames <= satInc(cntFrames, 1'b1);
            cntFcsErr <= satInc(cntFcsErr, crc != CRC32_RESIDUE);
            cntRunt   <= satInc(cntRunt, lenCnt < MIN_LEN_W);
            cntOvr    <= satInc(cntOvr, lenCnt > MAX_LEN_W);
          end
        end

        ST_DROP: begin
          if (!rx_dv) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Self-checking bench for gmii_rx_framer: directed scenarios plus random frames against a
// frame-level model (FCS computed over the payload, expected forwarding derived from frame length).
module tb_gmii_rx_framer;

  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;
  localparam int LEN_W   = 16;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int BUF_SZ  = 16384;

  typedef logic [7:0] byteQ_t[$];

  logic             CLOCK   = 1'b0;
  logic             RESET_N = 1'b0;
  logic             rx_dv   = 1'b0;
  logic             rx_er   = 1'b0;
  logic [7:0]       rxd     = 8'h00;
  logic             newpkt;
  logic             dataValid;
  logic [7:0]       data;
  logic             pktEnd;
  logic [LEN_W-1:0] pktLen;
  logic             fcsErr;
  logic             frameErr;
  logic             runt;
  logic             oversize;
  logic [CNT_W-1:0] cntFrames;
  logic [CNT_W-1:0] cntFcsErr;
  logic [CNT_W-1:0] cntRunt;
  logic [CNT_W-1:0] cntOvr;

  always #5 CLOCK = ~CLOCK;

  gmii_rx_framer #(
    .MAX_LEN (MAX_LEN),
    .MIN_LEN (MIN_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .rxd       (rxd),
    .newpkt    (newpkt),
    .dataValid (dataValid),
    .data      (data),
    .pktEnd    (pktEnd),
    .pktLen    (pktLen),
    .fcsErr    (fcsErr),
    .frameErr  (frameErr),
    .runt      (runt),
    .oversize  (oversize),
    .cntFrames (cntFrames),
    .cntFcsErr (cntFcsErr),
    .cntRunt   (cntRunt),
    .cntOvr    (cntOvr)
  );

  int checks = 0;
  int errors = 0;

  // Output monitor, sampled on the falling edge.
  int               nNew = 0, nEnd = 0, nDv = 0, nOverlap = 0;
  logic [7:0]       gotBytes [0:BUF_SZ-1];
  logic [LEN_W-1:0] endLen;
  logic             endFcs, endFrm, endRunt, endOvr;

  always @(negedge CLOCK) begin
    if (dataValid) begin
      if (nDv < BUF_SZ) gotBytes[nDv] = data;
      nDv++;
    end
    if (newpkt) nNew++;
    if (newpkt && dataValid) nOverlap++;
    if (pktEnd) begin
      nEnd++;
      endLen  = pktLen;
      endFcs  = fcsErr;
      endFrm  = frameErr;
      endRunt = runt;
      endOvr  = oversize;
    end
  end

  int baseNew, baseEnd, baseDv;
  int mFrames, mFcs, mRunt, mOvr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int satAdd(input int v, input bit en);
    if (!en) return v;
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Standard Ethernet FCS (byte-xor formulation), transmitted LSB first.
  function automatic logic [31:0] fcsOf(input byteQ_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic byteQ_t makeGood(input int n);
    byteQ_t q;
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) q.push_back(8'($urandom));
    f = fcsOf(q, n - 4);
    q.push_back(f[7:0]);
    q.push_back(f[15:8]);
    q.push_back(f[23:16]);
    q.push_back(f[31:24]);
    return q;
  endfunction

  task automatic drive(input logic dv, input logic er, input logic [7:0] b);
    @(negedge CLOCK);
    rx_dv = dv;
    rx_er = er;
    rxd   = b;
  endtask

  task automatic markBase();
    baseNew = nNew;
    baseEnd = nEnd;
    baseDv  = nDv;
  endtask

  task automatic sendFrame(input byteQ_t frm, input int preLen, input int erAt);
    markBase();
    for (int i = 0; i < preLen; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < frm.size(); i++) drive(1'b1, (i == erAt), frm[i]);
    drive(1'b0, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic applyReset();
    @(negedge CLOCK);
    RESET_N = 1'b0;
    rx_dv   = 1'b0;
    rx_er   = 1'b0;
    repeat (2) @(negedge CLOCK);
    RESET_N = 1'b1;
    mFrames = 0; mFcs = 0; mRunt = 0; mOvr = 0;
    repeat (2) @(negedge CLOCK);
  endtask

  // Byte k leaves when byte k+4 arrives, and only while the length is still within MAX_LEN.
  task automatic checkFrame(input byteQ_t frm, input bit erE);
    int   n, fwdE, lenE, mis, got;
    logic fcsE, runtE, ovrE;
    n    = frm.size();
    fwdE = ((n > MAX_LEN) ? MAX_LEN : n) - 4;
    if (fwdE < 0) fwdE = 0;
    lenE  = (n > MAX_LEN) ? MAX_LEN + 1 : n;
    fcsE  = (n < 4) ? 1'b1 : (fcsOf(frm, n - 4) != {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
    runtE = (lenE < MIN_LEN);
    ovrE  = (n > MAX_LEN);
    got   = nDv - baseDv;
    mis   = 0;
    for (int i = 0; i < fwdE && i < got; i++)
      if (gotBytes[baseDv + i] !== frm[i]) mis++;
    mFrames = satAdd(mFrames, 1'b1);
    mFcs    = satAdd(mFcs, fcsE);
    mRunt   = satAdd(mRunt, runtE);
    mOvr    = satAdd(mOvr, ovrE);
    check("newpkt count", nNew - baseNew, 1);
    check("dataValid count", got, fwdE);
    check("forwarded byte mismatches", mis, 0);
    check("pktEnd count", nEnd - baseEnd, 1);
    check("pktLen", endLen, lenE);
    check("fcsErr", endFcs, fcsE);
    check("frameErr", endFrm, erE);
    check("runt", endRunt, runtE);
    check("oversize", endOvr, ovrE);
    check("newpkt/dataValid overlap", nOverlap, 0);
    check("cntFrames", cntFrames, mFrames);
    check("cntFcsErr", cntFcsErr, mFcs);
    check("cntRunt", cntRunt, mRunt);
    check("cntOvr", cntOvr, mOvr);
  endtask

  task automatic checkSilent(input string tag);
    check({tag, " newpkt"}, nNew - baseNew, 0);
    check({tag, " dataValid"}, nDv - baseDv, 0);
    check({tag, " pktEnd"}, nEnd - baseEnd, 0);
  endtask

  initial begin
    byteQ_t f, f2;
    int     n, er;
    mFrames = 0; mFcs = 0; mRunt = 0; mOvr = 0;

    repeat (3) @(negedge CLOCK);
    check("reset newpkt", newpkt, 0);
    check("reset dataValid", dataValid, 0);
    check("reset data", data, 0);
    check("reset pktEnd", pktEnd, 0);
    check("reset pktLen", pktLen, 0);
    check("reset flags", {fcsErr, frameErr, runt, oversize}, 0);
    check("reset counters", {cntFrames, cntFcsErr, cntRunt, cntOvr}, 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLOCK);

    // Good 64-byte frame, then single-bit corruption, then rx_er mid-frame.
    f = makeGood(64);
    sendFrame(f, 7, -1);
    checkFrame(f, 1'b0);
    f2 = f;
    f2[20] = f2[20] ^ 8'h04;
    sendFrame(f2, 7, -1);
    checkFrame(f2, 1'b0);
    sendFrame(f, 7, 30);
    checkFrame(f, 1'b1);

    // Runts: 40-byte good frame and a 2-byte fragment.
    applyReset();
    f = makeGood(40);
    sendFrame(f, 7, -1);
    checkFrame(f, 1'b0);
    f = {};
    f.push_back(8'($urandom));
    f.push_back(8'($urandom));
    sendFrame(f, 7, -1);
    checkFrame(f, 1'b0);

    // Broken preamble goes to DROP; the next frame is unaffected.
    markBase();
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h54);
    repeat (10) drive(1'b1, 1'b0, 8'($urandom));
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    checkSilent("drop");
    f = makeGood(64 + $urandom_range(0, 16));
    sendFrame(f, 7, -1);
    checkFrame(f, 1'b0);

    // Random frames: length, preamble length, corruption and rx_er position all random.
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 90);
      f = (n >= 4) ? makeGood(n) : makeGood(4);
      while (f.size() > n) void'(f.pop_back());
      if ($urandom_range(0, 1) == 1) f[$urandom_range(0, n - 1)] ^= 8'h01 << $urandom_range(0, 7);
      er = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      sendFrame(f, $urandom_range(0, 7), er);
      checkFrame(f, er >= 0);
    end

    // Reset for two cycles at byte 100 of a 200-byte frame with rx_dv held.
    f = makeGood(200);
    for (int i = 0; i < 200; i++) if (f[i] == 8'h55 || f[i] == 8'hD5) f[i] = 8'h00;
    repeat (7) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, f[i]);
    @(negedge CLOCK);
    RESET_N = 1'b0;
    rxd     = f[100];
    mFrames = 0; mFcs = 0; mRunt = 0; mOvr = 0;
    #1;
    check("mid-reset dataValid", dataValid, 0);
    check("mid-reset pktEnd", pktEnd, 0);
    check("mid-reset cntFrames", cntFrames, 0);
    drive(1'b1, 1'b0, f[101]);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    rxd     = f[102];
    markBase();
    for (int i = 103; i < 200; i++) drive(1'b1, 1'b0, f[i]);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    checkSilent("after reset");
    f = makeGood(64);
    sendFrame(f, 7, -1);
    checkFrame(f, 1'b0);

    // Oversize frame.
    f = makeGood(1600);
    sendFrame(f, 7, -1);
    checkFrame(f, 1'b0);

    // Counter saturation with a 2-bit counter.
    applyReset();
    for (int t = 0; t < 5; t++) begin
      f = makeGood($urandom_range(64, 80));
      sendFrame(f, 7, -1);
      checkFrame(f, 1'b0);
    end
    check("cntFrames saturated", cntFrames, CNT_MAX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
